// File: rtl/spi_host_tlul.sv
// spi_host_tlul: TL-UL register front end driving a single-lane mode-0 SPI master.
// Holds a minimal TL-UL type package and response integrity generator so the file stands alone.
package tlul_pkg;
    typedef enum logic [2:0] {
        PutFullData    = 3'h0,
        PutPartialData = 3'h1,
        Get            = 3'h4
    } tl_a_op_e;
    typedef enum logic [2:0] {
        AccessAck     = 3'h0,
        AccessAckData = 3'h1
    } tl_d_op_e;
    typedef struct packed {
        logic [6:0] cmd_intg;
        logic [6:0] data_intg;
    } tl_a_user_t;
    typedef struct packed {
        logic [6:0] rsp_intg;
        logic [6:0] data_intg;
    } tl_d_user_t;
    typedef struct packed {
        logic       a_valid;
        tl_a_op_e   a_opcode;
        logic [2:0] a_param;
        logic [1:0] a_size;
        logic [7:0] a_source;
        logic [31:0] a_address;
        logic [3:0] a_mask;
        logic [31:0] a_data;
        tl_a_user_t a_user;
        logic       d_ready;
    } tl_h2d_t;
    typedef struct packed {
        logic       d_valid;
        tl_d_op_e   d_opcode;
        logic [2:0] d_param;
        logic [1:0] d_size;
        logic [7:0] d_source;
        logic       d_sink;
        logic [31:0] d_data;
        tl_d_user_t d_user;
        logic       d_error;
        logic       a_ready;
    } tl_d2h_t;
endpackage

module tlul_rsp_intg_gen
    import tlul_pkg::*;
(
    input  tl_d2h_t tl_i,
    output tl_d2h_t tl_o
);
    // Interleaved parity: bit k covers every input bit whose index is k mod 7.
    function automatic logic [6:0] fold7(input logic [31:0] v);
        logic [6:0] f;
        f = '0;
        for (int i = 0; i < 32; i++) f[i % 7] = f[i % 7] ^ v[i];
        return f;
    endfunction

    logic unused_user;
    assign unused_user = ^tl_i.d_user;

    always_comb begin
        tl_o = tl_i;
        tl_o.d_user.data_intg = fold7(tl_i.d_data);
        tl_o.d_user.rsp_intg = fold7({18'b0, tl_i.d_source, tl_i.d_opcode, tl_i.d_size, tl_i.d_error});
    end
endmodule

module spi_host_tlul
    import tlul_pkg::*;
#(
    parameter int AW = 5
) (
    input  logic    clk_i,
    input  logic    rst_i,
    input  tl_h2d_t tl_i,
    output tl_d2h_t tl_o,
    output logic    spi_sclk_o,
    output logic    spi_csn_o,
    output logic    spi_sdo_o,
    input  logic    spi_sdi_i,
    output logic    intr_done_o
);
    localparam logic [AW-3:0] OFF_CTRL   = (AW-2)'(0);
    localparam logic [AW-3:0] OFF_CLKDIV = (AW-2)'(1);
    localparam logic [AW-3:0] OFF_TXDATA = (AW-2)'(2);
    localparam logic [AW-3:0] OFF_RXDATA = (AW-2)'(3);
    localparam logic [AW-3:0] OFF_STATUS = (AW-2)'(4);

    typedef enum logic [1:0] {IDLE, LOW, HIGH, TRAIL} state_e;

    state_e      state, state_d;
    logic        rsp_pending, rsp_error;
    tl_d_op_e    rsp_opcode;
    logic [1:0]  rsp_size;
    logic [7:0]  rsp_source;
    logic [31:0] rsp_data;
    logic        cs_hold, ie, done;
    logic [4:0]  len, bitcnt;
    logic [15:0] clkdiv, hc;
    logic [31:0] txdata, rxdata, rx, rdata;
    logic [AW-3:0] idx;
    logic        accept, is_put, is_get, busy, err, wr, start, tick;
    tl_d2h_t     tl_raw;
    logic        unused_tl;

    assign unused_tl = ^{tl_i.a_param, tl_i.a_mask, tl_i.a_user, tl_i.a_address[31:AW], tl_i.a_address[1:0]};

    assign accept = tl_i.a_valid && !rsp_pending;
    assign is_put = tl_i.a_opcode inside {PutFullData, PutPartialData};
    assign is_get = tl_i.a_opcode == Get;
    assign idx = tl_i.a_address[AW-1:2];
    assign busy = state != IDLE;
    assign tick = hc == clkdiv;
    // Only STATUS stays writable mid-transfer so firmware can ack DONE without racing the shifter.
    assign err = !(is_put || is_get) || idx > OFF_STATUS ||
                 (is_put && (idx == OFF_RXDATA || (busy && idx != OFF_STATUS)));
    assign wr = accept && is_put && !err;
    assign start = wr && idx == OFF_CTRL && tl_i.a_data[0];
    assign intr_done_o = done && ie;

    assign rdata = idx == OFF_CTRL   ? {19'b0, len, 5'b0, ie, cs_hold, 1'b0} :
                   idx == OFF_CLKDIV ? {16'b0, clkdiv} :
                   idx == OFF_TXDATA ? txdata :
                   idx == OFF_RXDATA ? rxdata :
                   idx == OFF_STATUS ? {30'b0, done, busy} : '0;

    always_comb begin
        state_d = state;
        case (state)
            IDLE:  state_d = start ? LOW : IDLE;
            LOW:   state_d = tick ? HIGH : LOW;
            HIGH:  state_d = tick ? (bitcnt == 5'd0 ? TRAIL : LOW) : HIGH;
            TRAIL: state_d = tick ? IDLE : TRAIL;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state <= IDLE;
        else state <= state_d;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rsp_pending <= 1'b0;
            rsp_opcode <= AccessAck;
            rsp_size <= '0;
            rsp_source <= '0;
            rsp_data <= '0;
            rsp_error <= 1'b0;
        end else if (accept) begin
            rsp_pending <= 1'b1;
            rsp_opcode <= is_get ? AccessAckData : AccessAck;
            rsp_size <= tl_i.a_size;
            rsp_source <= tl_i.a_source;
            rsp_data <= (is_get && !err) ? rdata : '0;
            rsp_error <= err;
        end else if (tl_i.d_ready) begin
            rsp_pending <= 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cs_hold <= 1'b0;
            ie <= 1'b0;
            len <= '0;
            clkdiv <= '0;
            txdata <= '0;
            rxdata <= '0;
            rx <= '0;
            done <= 1'b0;
            hc <= '0;
            bitcnt <= '0;
            spi_sclk_o <= 1'b0;
            spi_csn_o <= 1'b1;
            spi_sdo_o <= 1'b0;
        end else begin
            if (wr && idx == OFF_CTRL) {len, ie, cs_hold} <= {tl_i.a_data[12:8], tl_i.a_data[2:1]};
            if (wr && idx == OFF_CLKDIV) clkdiv <= tl_i.a_data[15:0];
            if (wr && idx == OFF_TXDATA) txdata <= tl_i.a_data;
            if (wr && idx == OFF_STATUS && tl_i.a_data[1]) done <= 1'b0;
            if (wr && idx == OFF_CTRL && !tl_i.a_data[1]) spi_csn_o <= 1'b1;
            hc <= (state == IDLE || tick) ? '0 : hc + 16'd1;
            // Later assignments below take priority: START beats the csn release, completion beats DONE clear.
            case (state)
                IDLE: if (start) begin
                    spi_csn_o <= 1'b0;
                    spi_sdo_o <= txdata[tl_i.a_data[12:8]];
                    bitcnt <= tl_i.a_data[12:8];
                    rx <= '0;
                    done <= 1'b0;
                end
                LOW: if (tick) begin
                    spi_sclk_o <= 1'b1;
                    rx <= {rx[30:0], spi_sdi_i};
                end
                HIGH: if (tick) begin
                    spi_sclk_o <= 1'b0;
                    if (bitcnt != 5'd0) begin
                        bitcnt <= bitcnt - 5'd1;
                        spi_sdo_o <= txdata[bitcnt - 5'd1];
                    end
                end
                TRAIL: if (tick) begin
                    rxdata <= rx;
                    done <= 1'b1;
                    spi_csn_o <= !cs_hold;
                    spi_sdo_o <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        tl_raw = '0;
        tl_raw.d_valid = rsp_pending;
        tl_raw.d_opcode = rsp_opcode;
        tl_raw.d_size = rsp_size;
        tl_raw.d_source = rsp_source;
        tl_raw.d_data = rsp_data;
        tl_raw.d_error = rsp_error;
        tl_raw.a_ready = !rsp_pending;
    end

    tlul_rsp_intg_gen u_intg (
        .tl_i(tl_raw),
        .tl_o(tl_o)
    );
endmodule

// File: tb/tb_spi_host_tlul.sv
// tb_spi_host_tlul: directed register and SPI waveform checks for spi_host_tlul.
module tb_spi_host_tlul;
    import tlul_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    tl_h2d_t tl_i;
    tl_d2h_t tl_o;
    logic sclk, csn, sdo, sdi, intr;
    logic loopback = 1'b0;
    logic sdi_val = 1'b0;
    int cyc = 0;
    int checks = 0;
    int errors = 0;
    logic [31:0] rsp_data;
    logic rsp_err;
    logic [2:0] rsp_op;
    logic [7:0] rsp_src;
    logic [1:0] rsp_size;
    int rsp_lat;
    int w_rises, w_done;
    logic [31:0] w_bits;
    bit w_pok;
    logic unused_rsp;

    assign sdi = loopback ? sdo : sdi_val;
    assign unused_rsp = ^{tl_o.d_param, tl_o.d_sink, tl_o.d_user};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    spi_host_tlul #(.AW(5)) dut (
        .clk_i(clk),
        .rst_i(rst),
        .tl_i(tl_i),
        .tl_o(tl_o),
        .spi_sclk_o(sclk),
        .spi_csn_o(csn),
        .spi_sdo_o(sdo),
        .spi_sdi_i(sdi),
        .intr_done_o(intr)
    );

    // Issues one request and returns at the first negedge with d_valid (response consumed on the next edge).
    task automatic tl_req(input bit now, input tl_a_op_e op, input logic [31:0] addr, input logic [31:0] data);
        int w;
        if (!now) @(negedge clk);
        tl_i.a_valid = 1'b1;
        tl_i.a_opcode = op;
        tl_i.a_address = addr;
        tl_i.a_data = data;
        tl_i.a_mask = 4'hF;
        tl_i.a_size = 2'd2;
        tl_i.a_source = 8'h5A;
        tl_i.d_ready = 1'b1;
        w = 0;
        while (!tl_o.a_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        if (w == 20) begin
            errors++;
            $display("FAIL a_ready_timeout: got 0 want 1");
        end
        @(negedge clk);
        tl_i.a_valid = 1'b0;
        rsp_lat = 1;
        while (!tl_o.d_valid && rsp_lat < 10) begin
            @(negedge clk);
            rsp_lat++;
        end
        rsp_data = tl_o.d_data;
        rsp_err = tl_o.d_error;
        rsp_op = tl_o.d_opcode;
        rsp_src = tl_o.d_source;
        rsp_size = tl_o.d_size;
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] data);
        tl_req(1'b0, PutFullData, addr, data);
    endtask

    task automatic rd(input logic [31:0] addr);
        tl_req(1'b0, Get, addr, 32'h0);
    endtask

    // Follows the transfer until csn rises or the interrupt fires, collecting SDO at each SCLK rise.
    task automatic watch(input int t0, input int d);
        logic prev;
        prev = sclk;
        w_rises = 0;
        w_bits = '0;
        w_done = -1;
        w_pok = 1'b1;
        for (int i = 0; i < 400 && w_done < 0; i++) begin
            @(negedge clk);
            if (sclk && !prev) begin
                if (cyc != t0 + d + 2 * d * w_rises) w_pok = 1'b0;
                w_bits = {w_bits[30:0], sdo};
                w_rises++;
            end
            prev = sclk;
            if (intr || csn) w_done = cyc - t0;
        end
        if (w_done < 0) begin
            errors++;
            $display("FAIL xfer_timeout: got none want done");
        end
    endtask

    task automatic test_reset();
        tl_i = '0;
        tl_i.d_ready = 1'b1;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if ({tl_o.d_valid, tl_o.a_ready, sclk, csn, sdo, intr} !== 6'b010100) begin errors++; $display("FAIL reset_outputs: got %b want 010100", {tl_o.d_valid, tl_o.a_ready, sclk, csn, sdo, intr}); end
        rst = 1'b0;
        rd(32'h10);
        checks++; if (rsp_lat !== 1) begin errors++; $display("FAIL get_latency: got %0d want 1", rsp_lat); end
        checks++; if (rsp_op !== 3'h1) begin errors++; $display("FAIL get_opcode: got %h want 1", rsp_op); end
        checks++; if ({rsp_err, rsp_data} !== 33'h0) begin errors++; $display("FAIL status_reset: got %h want 0", {rsp_err, rsp_data}); end
        checks++; if ({rsp_src, rsp_size} !== {8'h5A, 2'd2}) begin errors++; $display("FAIL echo: got %h want 16a", {rsp_src, rsp_size}); end
        rd(32'h0);
        checks++; if (rsp_data !== 32'h0) begin errors++; $display("FAIL ctrl_reset: got %h want 0", rsp_data); end
        rd(32'hC);
        checks++; if (rsp_data !== 32'h0) begin errors++; $display("FAIL rxdata_reset: got %h want 0", rsp_data); end
    endtask

    task automatic test_loopback();
        int t0;
        wr(32'h4, 32'h1);
        wr(32'h8, 32'hA5);
        wr(32'h0, 32'h0701);
        t0 = cyc;
        loopback = 1'b1;
        checks++; if ({rsp_op, rsp_err} !== 4'h0) begin errors++; $display("FAIL put_ack: got %h want 0", {rsp_op, rsp_err}); end
        checks++; if ({csn, sdo} !== 2'b01) begin errors++; $display("FAIL first_bit: got %b want 01", {csn, sdo}); end
        watch(t0, 2);
        checks++; if (w_rises !== 8) begin errors++; $display("FAIL lb_rises: got %0d want 8", w_rises); end
        checks++; if (w_bits !== 32'hA5) begin errors++; $display("FAIL lb_sdo_bits: got %h want a5", w_bits); end
        checks++; if (w_pok !== 1'b1) begin errors++; $display("FAIL lb_period: got %b want 1", w_pok); end
        checks++; if (w_done !== 34) begin errors++; $display("FAIL lb_done_time: got %0d want 34", w_done); end
        checks++; if ({csn, intr} !== 2'b10) begin errors++; $display("FAIL lb_end: got %b want 10", {csn, intr}); end
        rd(32'h10);
        checks++; if (rsp_data !== 32'h2) begin errors++; $display("FAIL lb_status: got %h want 2", rsp_data); end
        rd(32'hC);
        checks++; if (rsp_data !== 32'hA5) begin errors++; $display("FAIL lb_rxdata: got %h want a5", rsp_data); end
        loopback = 1'b0;
    endtask

    task automatic test_long_ie();
        int t0;
        sdi_val = 1'b1;
        wr(32'h4, 32'h0);
        wr(32'h8, 32'hDEADBEEF);
        wr(32'h0, 32'h1F05);
        t0 = cyc;
        watch(t0, 1);
        checks++; if (w_rises !== 32) begin errors++; $display("FAIL long_rises: got %0d want 32", w_rises); end
        checks++; if (w_bits !== 32'hDEADBEEF) begin errors++; $display("FAIL long_sdo_bits: got %h want deadbeef", w_bits); end
        checks++; if (w_done !== 65) begin errors++; $display("FAIL long_done_time: got %0d want 65", w_done); end
        checks++; if (intr !== 1'b1) begin errors++; $display("FAIL long_intr: got %b want 1", intr); end
        rd(32'hC);
        checks++; if (rsp_data !== 32'hFFFFFFFF) begin errors++; $display("FAIL long_rxdata: got %h want ffffffff", rsp_data); end
        wr(32'h10, 32'h2);
        checks++; if (intr !== 1'b0) begin errors++; $display("FAIL done_clear_intr: got %b want 0", intr); end
        rd(32'h10);
        checks++; if (rsp_data !== 32'h0) begin errors++; $display("FAIL done_clear_status: got %h want 0", rsp_data); end
        sdi_val = 1'b0;
        wr(32'h0, 32'h0);
    endtask

    task automatic test_busy_errors();
        int t0;
        wr(32'h4, 32'h3);
        wr(32'h8, 32'h3C);
        wr(32'h0, 32'h0701);
        t0 = cyc;
        loopback = 1'b1;
        wr(32'h8, 32'h12345678);
        checks++; if (rsp_err !== 1'b1) begin errors++; $display("FAIL busy_txdata_err: got %b want 1", rsp_err); end
        rd(32'h10);
        checks++; if ({rsp_err, rsp_data} !== 33'h1) begin errors++; $display("FAIL busy_status: got %h want 1", {rsp_err, rsp_data}); end
        wr(32'h10, 32'h2);
        checks++; if (rsp_err !== 1'b0) begin errors++; $display("FAIL busy_status_wr: got %b want 0", rsp_err); end
        wr(32'h0, 32'h0);
        checks++; if ({rsp_err, csn} !== 2'b10) begin errors++; $display("FAIL busy_ctrl_err: got %b want 10", {rsp_err, csn}); end
        watch(t0, 4);
        checks++; if (w_done !== 68) begin errors++; $display("FAIL busy_done_time: got %0d want 68", w_done); end
        rd(32'h8);
        checks++; if (rsp_data !== 32'h3C) begin errors++; $display("FAIL txdata_kept: got %h want 3c", rsp_data); end
        rd(32'hC);
        checks++; if (rsp_data !== 32'h3C) begin errors++; $display("FAIL busy_rxdata: got %h want 3c", rsp_data); end
        rd(32'h14);
        checks++; if (rsp_err !== 1'b1) begin errors++; $display("FAIL unmapped_err: got %b want 1", rsp_err); end
        wr(32'hC, 32'h5);
        checks++; if (rsp_err !== 1'b1) begin errors++; $display("FAIL rxdata_wr_err: got %b want 1", rsp_err); end
        rd(32'hC);
        checks++; if (rsp_data !== 32'h3C) begin errors++; $display("FAIL rxdata_kept: got %h want 3c", rsp_data); end
        loopback = 1'b0;
    endtask

    task automatic test_back_to_back();
        int t0, t1;
        wr(32'h4, 32'h0);
        wr(32'h8, 32'h81);
        wr(32'h0, 32'h0707);
        t0 = cyc;
        watch(t0, 1);
        checks++; if ({w_done, csn, intr} !== {32'd17, 2'b01}) begin errors++; $display("FAIL hold_first_end: got %0d/%b want 17/01", w_done, {csn, intr}); end
        checks++; if (w_bits !== 32'h81) begin errors++; $display("FAIL hold_sdo_bits: got %h want 81", w_bits); end
        tl_req(1'b1, PutFullData, 32'h0, 32'h0707);
        t1 = cyc;
        checks++; if ({rsp_err, csn, intr} !== 3'b000) begin errors++; $display("FAIL b2b_start: got %b want 000", {rsp_err, csn, intr}); end
        checks++; if (t1 !== t0 + 18) begin errors++; $display("FAIL b2b_accept_time: got %0d want %0d", t1, t0 + 18); end
        watch(t1, 1);
        checks++; if ({w_done, csn} !== {32'd17, 1'b0}) begin errors++; $display("FAIL hold_second_end: got %0d/%b want 17/0", w_done, csn); end
        wr(32'h0, 32'h0);
        checks++; if ({csn, intr} !== 2'b10) begin errors++; $display("FAIL hold_release: got %b want 10", {csn, intr}); end
    endtask

    task automatic test_reset_midxfer();
        int t0, toggles;
        logic prev;
        wr(32'h4, 32'h1);
        wr(32'h8, 32'hFF);
        wr(32'h0, 32'h0701);
        t0 = cyc;
        for (int i = 0; i < 50 && cyc < t0 + 14; i++) @(negedge clk);
        tl_i.a_valid = 1'b1;
        tl_i.a_opcode = Get;
        tl_i.a_address = 32'h10;
        tl_i.d_ready = 1'b0;
        @(negedge clk);
        tl_i.a_valid = 1'b0;
        checks++; if ({tl_o.d_valid, tl_o.d_data} !== {1'b1, 32'h1}) begin errors++; $display("FAIL stall_rsp: got %h want 100000001", {tl_o.d_valid, tl_o.d_data}); end
        toggles = 0;
        prev = sclk;
        repeat (4) begin
            @(negedge clk);
            if (sclk !== prev) toggles++;
            prev = sclk;
        end
        checks++; if ({tl_o.d_valid, tl_o.a_ready, tl_o.d_data} !== {2'b10, 32'h1}) begin errors++; $display("FAIL stall_hold: got %h want 200000001", {tl_o.d_valid, tl_o.a_ready, tl_o.d_data}); end
        checks++; if (toggles !== 2) begin errors++; $display("FAIL stall_sclk: got %0d want 2", toggles); end
        rst = 1'b1;
        @(posedge clk);
        #1;
        checks++; if ({tl_o.d_valid, tl_o.a_ready, sclk, csn, sdo, intr} !== 6'b010100) begin errors++; $display("FAIL midreset_outputs: got %b want 010100", {tl_o.d_valid, tl_o.a_ready, sclk, csn, sdo, intr}); end
        @(negedge clk);
        rst = 1'b0;
        tl_i.d_ready = 1'b1;
        rd(32'h10);
        checks++; if (rsp_data !== 32'h0) begin errors++; $display("FAIL midreset_status: got %h want 0", rsp_data); end
        rd(32'h8);
        checks++; if (rsp_data !== 32'h0) begin errors++; $display("FAIL midreset_txdata: got %h want 0", rsp_data); end
    endtask

    initial begin
        test_reset();
        test_loopback();
        test_long_ie();
        test_busy_errors();
        test_back_to_back();
        test_reset_midxfer();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
